// File: rtl/gpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : gpr_wb_arbiter
// Description : Round-robin arbiter sharing the single register-file write
//               port among the ALU, LOAD and MDU writeback sources. The
//               selected write is registered onto RegWrite/Rd/WData, and a
//               pending-write scoreboard drives the decode-stage read stall.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,

    // writeback requesters
    input  logic              alu_req,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_gnt,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_gnt,

    input  logic              mdu_req,
    input  logic [ADDR_W-1:0] mdu_rd,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_gnt,

    // decode-stage issue and hazard interface
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] rs_idx,
    input  logic [ADDR_W-1:0] rt_idx,
    output logic              stall,

    // register-file write port
    output logic              RegWrite,
    output logic [ADDR_W-1:0] Rd,
    output logic [DATA_W-1:0] WData
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    // round-robin pointer: index of the most recently granted source
    src_e              last_q, last_d;

    // current-cycle grant decision
    logic              gnt_any;
    src_e              gnt_src;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // writeback register
    logic              we_q, we_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // pending-write scoreboard, one bit per architectural register
    logic [NREG-1:0]   pend_q, pend_d;

    // Round-robin search starting one past the last winner; nothing is
    // granted while Reset is high so a mid-transfer reset drops the handshake.
    always_comb begin
        gnt_any = 1'b0;
        gnt_src = last_q;
        if (!Reset) begin
            case (last_q)
                SRC_ALU: begin
                    if (ld_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_LD;
                    end else if (mdu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_MDU;
                    end else if (alu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_ALU;
                    end
                end
                SRC_LD: begin
                    if (mdu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_MDU;
                    end else if (alu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_ALU;
                    end else if (ld_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_LD;
                    end
                end
                default: begin
                    if (alu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_ALU;
                    end else if (ld_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_LD;
                    end else if (mdu_req) begin
                        gnt_any = 1'b1; gnt_src = SRC_MDU;
                    end
                end
            endcase
        end
    end

    assign alu_gnt = gnt_any && (gnt_src == SRC_ALU);
    assign ld_gnt  = gnt_any && (gnt_src == SRC_LD);
    assign mdu_gnt = gnt_any && (gnt_src == SRC_MDU);

    // Route the winning source's destination and value toward the write port.
    always_comb begin
        case (gnt_src)
            SRC_ALU: begin
                sel_rd   = alu_rd;
                sel_data = alu_data;
            end
            SRC_LD: begin
                sel_rd   = ld_rd;
                sel_data = ld_data;
            end
            default: begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
            end
        endcase
    end

    // Next-state for pointer and writeback register; a grant to r0 completes
    // the handshake but is swallowed here, and Rd/WData hold when idle.
    always_comb begin
        last_d  = gnt_any ? gnt_src : last_q;
        we_d    = gnt_any && (sel_rd != '0);
        rd_d    = rd_q;
        wdata_d = wdata_q;
        if (we_d) begin
            rd_d    = sel_rd;
            wdata_d = sel_data;
        end
    end

    // Scoreboard next-state: the clear from a completing grant is applied
    // first so that a same-edge issue to that register (a younger producer)
    // leaves the bit set. r0 is hardwired and never pending.
    always_comb begin
        pend_d = pend_q;
        if (gnt_any) begin
            pend_d[sel_rd] = 1'b0;
        end
        if (issue_valid) begin
            pend_d[issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // State registers with synchronous reset; ALU gets first priority out of
    // reset because the pointer starts at MDU.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_q  <= SRC_MDU;
            we_q    <= 1'b0;
            rd_q    <= '0;
            wdata_q <= '0;
            pend_q  <= '0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            wdata_q <= wdata_d;
            pend_q  <= pend_d;
        end
    end

    assign RegWrite = we_q;
    assign Rd       = rd_q;
    assign WData    = wdata_q;

    // A register is hazardous while its producer is outstanding, and also for
    // the one cycle its value sits in the writeback register before the
    // register file commits it.
    function automatic logic inflight(input logic [ADDR_W-1:0] idx);
        return we_q && (rd_q == idx) && (idx != '0);
    endfunction

    assign stall = pend_q[rs_idx] | pend_q[rt_idx] | inflight(rs_idx) | inflight(rt_idx);

endmodule
`default_nettype wire
